round_sequencer: RTL and testbench
==================================

# round_sequencer

Multi-round game controller for the reaction-speed game. Runs a fixed number of rounds, each with a pseudo-random arming delay, LED go signal and millisecond reaction count. Records per-round time, best time and running sum for the hex display path. It sits between the debounced KEY inputs, the 1 ms tick from the clock divider, the LED controller and the BCD/hex display logic.

## Interface
- ROUNDS, 5: rounds per game (1..7)
- MIN_DELAY_MS, 1000: minimum arming delay
- DELAY_MASK, 16'h07FF: mask applied to the LFSR value; delay = MIN_DELAY_MS + (lfsr & DELAY_MASK)
- TIMEOUT_MS, 9999: reaction saturation and timeout value
- TIME_W, 14: width of time outputs
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  synchronous reset, active-low
- tick_1ms  in  1  single-cycle enable, once per ms
- start  in  1  single-cycle pulse, begins a game
- stop  in  1  single-cycle pulse, player response
- led_flag  out  1  go-LED request
- busy  out  1  game in progress
- done  out  1  game complete; stats valid
- foul  out  1  last round was a false start
- round  out  3  rounds completed (0..ROUNDS)
- rxn_ms  out  TIME_W  last recorded round time
- best_ms  out  TIME_W  minimum recorded time this game
- sum_ms  out  TIME_W+3  sum of recorded times this game

## Operation
- States: IDLE, ARM, GO, RESULT, FOUL, DONE.
- IDLE: start moves to ARM. Entering ARM from IDLE or DONE clears round, rxn_ms, foul and sum_ms, and sets best_ms to TIMEOUT_MS.
- ARM: delay counter loads on entry. Each tick_1ms decrements it. Tick with counter==1 moves to GO.
- GO: led_flag=1. The reaction counter clears on entry and increments on each tick. Stop moves to RESULT with value=count. If count reaches TIMEOUT_MS, move to RESULT with value=TIMEOUT_MS (saturating).
- FOUL: one cycle. Sets foul=1, value=TIMEOUT_MS (penalty), then continues as RESULT.
- RESULT: one cycle.
  - rxn_ms<=value; sum_ms+=value; best_ms<=min(best_ms,value); round+=1.
  - If round+1==ROUNDS, go to DONE; else go to ARM (foul cleared on re-entry).
- DONE: done=1. Stats hold. Start restarts at ARM.
- LFSR: 16-bit, polynomial x^16+x^14+x^13+x^11+1. Advances every clk cycle, so human timing randomises it. Sampled on ARM entry.
- start while busy: ignored. stop in IDLE, RESULT or DONE: ignored.
- Simultaneous stop and tick in GO: stop wins; count not incremented.
- Simultaneous start and stop in IDLE/DONE: start taken.
- sum_ms width covers 7×9999 with no overflow.

## Timing
- Reset values:
  - All outputs 0, except best_ms=TIMEOUT_MS.
  - State IDLE.
  - LFSR=16'hACE1. The LFSR never becomes zero.
- start → ARM: next edge. busy rises the same edge.
- ARM → GO: the edge after the final tick. led_flag is registered and rises that edge.
- stop in GO → RESULT on the next edge. led_flag falls the same edge. Stats update on the following edge.
- Reaction count = number of ticks seen in GO before stop.
- Reset mid-game: all state returns to reset values on the edge; no partial stats retained.

## Configuration
- FALSE_START_EN.
  - Defined: stop during ARM moves to FOUL (penalty round).
  - Undefined: stop during ARM is ignored; the FOUL state is not compiled, and foul is tied 0.

## Structure
- game_pkg holds:
  - state enum (round_state_t)
  - LFSR seed and tap constants
  - the TIME_W default
- Sub-module lfsr16: clk, rst_n, out[15:0], free-running. Reusable by other game modes.
- round_sequencer: FSM, delay counter, reaction counter, stats registers.

## Test plan
- Set ROUNDS=2, MIN_DELAY_MS=3, DELAY_MASK=0. Pulse start, then stop 5 ticks after led_flag. Required:
  - GO after 3 ticks.
  - rxn_ms=5, round=1, best_ms=5.
  - Second round stop at 7 → sum_ms=12, best_ms=5, done=1.
- Run GO with no stop. Required: rxn_ms=TIMEOUT_MS (9999) after 9999 ticks; led_flag falls.
- With FALSE_START_EN defined, stop during ARM. Required: foul=1, rxn_ms=9999, round increments, next round arms. Without the macro: no state change.
- Stop and tick in the same cycle in GO at count 4. Required: rxn_ms=4.
- rst_n low during GO at round 1. Required: next edge gives IDLE, led_flag=0, round=0, best_ms=9999, sum_ms=0.
- Start during ARM or GO: ignored. Start in DONE: stats cleared, ARM entered, busy=1, done=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-speed game modes.
// Holds the round state encoding, LFSR seed/taps and the default time width.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    GO     = 3'd2,
    RESULT = 3'd3,
    FOUL   = 3'd4,
    DONE   = 3'd5
  } round_state_t;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting right: bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS  = 16'h002D;
  localparam int          TIME_W_DEF = 14;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Game-control bus between the input/tick sources and the round sequencer.
// master drives tick/start/stop; slave (the sequencer) drives status and stats.
interface round_sequencer_if
  import game_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) ();
  logic              tick_1ms;
  logic              start;
  logic              stop;
  logic              led_flag;
  logic              busy;
  logic              done;
  logic              foul;
  logic [2:0]        round;
  logic [TIME_W-1:0] rxn_ms;
  logic [TIME_W-1:0] best_ms;
  logic [TIME_W+2:0] sum_ms;

  modport master (
    output tick_1ms, start, stop,
    input  led_flag, busy, done, foul, round, rxn_ms, best_ms, sum_ms
  );

  modport slave (
    input  tick_1ms, start, stop,
    output led_flag, busy, done, foul, round, rxn_ms, best_ms, sum_ms
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit LFSR; never reaches zero from the non-zero seed.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);
  always_ff @(posedge clk) begin
    if (!rst_n) out <= LFSR_SEED;
    else        out <= lfsr_next(out);
  end
endmodule

// File: rtl/round_sequencer.sv
// Multi-round reaction game controller: arming delay, go LED, reaction timing and stats.
// Optional macro FALSE_START_EN: stop during ARM becomes a penalised FOUL round.
module round_sequencer
  import game_pkg::*;
#(
  parameter int          ROUNDS       = 5,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] DELAY_MASK   = 16'h07FF,
  parameter int          TIMEOUT_MS   = 9999,
  parameter int          TIME_W       = TIME_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  round_sequencer_if.slave   gi
);

  localparam logic [16:0]       MIN_D   = 17'(MIN_DELAY_MS);
  localparam logic [TIME_W-1:0] T_OUT   = TIME_W'(TIMEOUT_MS);
  localparam logic [TIME_W-1:0] T_LIMIT = TIME_W'(TIMEOUT_MS - 1);
  localparam logic [2:0]        N_RND   = 3'(ROUNDS);

  function automatic logic [TIME_W-1:0] min_time(input logic [TIME_W-1:0] a,
                                                 input logic [TIME_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  round_state_t      state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [16:0]       delay_q;
  logic [TIME_W-1:0] rxn_cnt_q;
  logic [TIME_W-1:0] val_q;
  logic [2:0]        round_q;
  logic [TIME_W-1:0] rxn_q;
  logic [TIME_W-1:0] best_q;
  logic [TIME_W+2:0] sum_q;
  logic              new_game;
  logic              at_limit;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr_q)
  );

  assign new_game = ((state_q == IDLE) || (state_q == DONE)) && gi.start;
  assign at_limit = (rxn_cnt_q >= T_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (gi.start) state_d = ARM;
      ARM: begin
`ifdef FALSE_START_EN
        if (gi.stop) state_d = FOUL;
        else if (gi.tick_1ms && (delay_q <= 17'd1)) state_d = GO;
`else
        if (gi.tick_1ms && (delay_q <= 17'd1)) state_d = GO;
`endif
      end
      // stop has priority over a coincident tick
      GO: begin
        if (gi.stop) state_d = RESULT;
        else if (gi.tick_1ms && at_limit) state_d = RESULT;
      end
`ifdef FALSE_START_EN
      FOUL: state_d = RESULT;
`endif
      RESULT: state_d = ((round_q + 3'd1) == N_RND) ? DONE : ARM;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gi.led_flag = (state_q == GO);
    gi.busy     = (state_q == ARM) || (state_q == GO) ||
                  (state_q == RESULT) || (state_q == FOUL);
    gi.done     = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q   <= '0;
      rxn_cnt_q <= '0;
      val_q     <= '0;
      round_q   <= '0;
      rxn_q     <= '0;
      best_q    <= T_OUT;
      sum_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (new_game) begin
            round_q <= '0;
            rxn_q   <= '0;
            best_q  <= T_OUT;
            sum_q   <= '0;
          end
        end
        ARM: if (gi.tick_1ms) delay_q <= delay_q - 17'd1;
        GO: begin
          if (gi.stop) begin
            val_q <= rxn_cnt_q;
          end else if (gi.tick_1ms) begin
            rxn_cnt_q <= rxn_cnt_q + 1'b1;
            if (at_limit) val_q <= T_OUT;
          end
        end
`ifdef FALSE_START_EN
        FOUL: val_q <= T_OUT;
`endif
        RESULT: begin
          rxn_q   <= val_q;
          sum_q   <= sum_q + (TIME_W+3)'(val_q);
          best_q  <= min_time(best_q, val_q);
          round_q <= round_q + 3'd1;
        end
        default: ;
      endcase
      // Delay and reaction counters load on state entry, overriding the case above
      if ((state_d == ARM) && (state_q != ARM))
        delay_q <= MIN_D + {1'b0, lfsr_q & DELAY_MASK};
      if ((state_d == GO) && (state_q != GO))
        rxn_cnt_q <= '0;
    end
  end

`ifdef FALSE_START_EN
  logic foul_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                          foul_q <= 1'b0;
    else if (state_q == FOUL)                            foul_q <= 1'b1;
    else if (new_game || ((state_q == RESULT) && (state_d == ARM))) foul_q <= 1'b0;
  end
  assign gi.foul = foul_q;
`else
  assign gi.foul = 1'b0;
`endif

  assign gi.round   = round_q;
  assign gi.rxn_ms  = rxn_q;
  assign gi.best_ms = best_q;
  assign gi.sum_ms  = sum_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer with a 2-round, 3 ms fixed-delay game.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int TW = 14;
  localparam int TO = 9999;

  logic clk;
  logic rst_n;

  round_sequencer_if #(.TIME_W(TW)) bus ();

  round_sequencer #(
    .ROUNDS       (2),
    .MIN_DELAY_MS (3),
    .DELAY_MASK   (16'h0000),
    .TIMEOUT_MS   (TO),
    .TIME_W       (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gi    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rxn;
    int rnd;
    int best;
    int sum;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_round, m_best, m_sum;
  int   prev_round = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic p);
    bus.tick_1ms = t;
    bus.start    = s;
    bus.stop     = p;
    @(posedge clk);
    #1;
    bus.tick_1ms = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
  endtask

  task automatic push_exp(input int v);
    exp_t e;
    m_round++;
    m_sum += v;
    if (v < m_best) m_best = v;
    e.rxn = v; e.rnd = m_round; e.best = m_best; e.sum = m_sum;
    sb.push_back(e);
  endtask

  task automatic start_game();
    step(1'b0, 1'b1, 1'b0);
    m_round = 0; m_best = TO; m_sum = 0;
    check("start_busy",  32'(bus.busy),    32'd1);
    check("start_done",  32'(bus.done),    32'd0);
    check("start_round", 32'(bus.round),   32'd0);
    check("start_best",  32'(bus.best_ms), 32'(TO));
    check("start_sum",   32'(bus.sum_ms),  32'd0);
    check("start_rxn",   32'(bus.rxn_ms),  32'd0);
  endtask

  // Three ticks through ARM; the LED must appear on the third
  task automatic arm_round();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("arm_led_low", 32'(bus.led_flag), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("go_after_3", 32'(bus.led_flag), 32'd1);
  endtask

  task automatic run_timeout();
    repeat (TO - 1) step(1'b1, 1'b0, 1'b0);
    check("pre_timeout_led", 32'(bus.led_flag), 32'd1);
    push_exp(TO);
    step(1'b1, 1'b0, 1'b0);
    check("timeout_led_fall", 32'(bus.led_flag), 32'd0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Pop one expected record each time the round count steps up
  always @(negedge clk) begin
    if (rst_n && (int'(bus.round) == prev_round + 1)) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rxn",   32'(bus.rxn_ms),  32'(e.rxn));
        check("sb_round", 32'(bus.round),   32'(e.rnd));
        check("sb_best",  32'(bus.best_ms), 32'(e.best));
        check("sb_sum",   32'(bus.sum_ms),  32'(e.sum));
      end
    end
    prev_round = int'(bus.round);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.tick_1ms = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_led",   32'(bus.led_flag), 32'd0);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    check("rst_foul",  32'(bus.foul),     32'd0);
    check("rst_round", 32'(bus.round),    32'd0);
    check("rst_rxn",   32'(bus.rxn_ms),   32'd0);
    check("rst_best",  32'(bus.best_ms),  32'(TO));
    check("rst_sum",   32'(bus.sum_ms),   32'd0);

    // Game 1: stops at 5 and 7
    start_game();
    arm_round();
    repeat (5) step(1'b1, 1'b0, 1'b0);
    push_exp(5);
    step(1'b0, 1'b0, 1'b1);
    check("stop_led_fall", 32'(bus.led_flag), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("r1_rearm_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("start_in_arm_round", 32'(bus.round),    32'd1);
    check("start_in_arm_led",   32'(bus.led_flag), 32'd0);
    arm_round();
    step(1'b0, 1'b1, 1'b0);
    check("start_in_go_led", 32'(bus.led_flag), 32'd1);
    check("start_in_go_rxn", 32'(bus.rxn_ms),   32'd5);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    push_exp(7);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("g1_done", 32'(bus.done), 32'd1);
    check("g1_busy", 32'(bus.busy), 32'd0);

    // Game 2: restart from DONE, stop during ARM
    start_game();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
`ifdef FALSE_START_EN
    step(1'b0, 1'b0, 1'b0);
    check("foul_flag", 32'(bus.foul), 32'd1);
    push_exp(TO);
    step(1'b0, 1'b0, 1'b0);
    check("foul_rearm_busy", 32'(bus.busy),     32'd1);
    check("foul_rearm_led",  32'(bus.led_flag), 32'd0);
    arm_round();
    repeat (4) step(1'b1, 1'b0, 1'b0);
    push_exp(4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("g2_done", 32'(bus.done), 32'd1);
`else
    check("arm_stop_busy",  32'(bus.busy),     32'd1);
    check("arm_stop_led",   32'(bus.led_flag), 32'd0);
    check("arm_stop_round", 32'(bus.round),    32'd0);
    check("arm_stop_foul",  32'(bus.foul),     32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("arm_stop_go", 32'(bus.led_flag), 32'd1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    push_exp(4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    arm_round();
    run_timeout();
    check("g2_done", 32'(bus.done), 32'd1);
`endif

    // Game 3: timeout round, then reset while in GO of round 2
    start_game();
    arm_round();
    run_timeout();
    arm_round();
    repeat (2) step(1'b1, 1'b0, 1'b0);
    check("pre_reset_round", 32'(bus.round), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_led",   32'(bus.led_flag), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_round", 32'(bus.round),    32'd0);
    check("mid_rst_best",  32'(bus.best_ms),  32'(TO));
    check("mid_rst_sum",   32'(bus.sum_ms),   32'd0);
    check("mid_rst_rxn",   32'(bus.rxn_ms),   32'd0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("idle_tick_busy", 32'(bus.busy), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
